// File: rtl/edge_result_wb_ctrl.sv
// rtl/edge_result_wb_ctrl.sv - sequences one edge-detect job and writes its result pixels plus a status line to host memory
// Optional feature macro: EDGE_WB_PERF_CNT_EN (job cycle counter reported in status line bits [127:96]).
module edge_result_wb_ctrl #(
    parameter int NUM_PIXELS = 307200,
    parameter int RD_ADDR_W  = 19,
    parameter int RD_LAT     = 1,
    parameter int ADDR_W     = 42
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cfg_start,
    input  logic [ADDR_W-1:0]    cfg_dst_addr,
    input  logic [ADDR_W-1:0]    cfg_status_addr,
    output logic                 acc_start,
    input  logic                 acc_done,
    output logic [RD_ADDR_W-1:0] acc_rd_addr,
    input  logic [23:0]          acc_rd_data,
    input  logic                 c1_alm_full,
    output logic                 wr_valid,
    output logic [ADDR_W-1:0]    wr_addr,
    output logic [511:0]         wr_data,
    output logic                 busy,
    output logic [31:0]          lines_written
);
    typedef enum logic [2:0] {S_IDLE, S_RUN, S_FILL, S_SEND, S_STATUS} state_t;
    localparam logic [31:0] NUM_PIX32 = 32'(NUM_PIXELS);

    state_t               r_state;
    logic                 r_acc_start;
    logic                 r_wr_valid;
    logic                 r_busy;
    logic [RD_ADDR_W-1:0] r_acc_rd_addr;
    logic [ADDR_W-1:0]    r_dst_addr;
    logic [ADDR_W-1:0]    r_status_addr;
    logic [ADDR_W-1:0]    r_wr_addr;
    logic [511:0]         r_wr_data;
    logic [31:0]          r_lines_written;
    logic [31:0]          r_pix_idx;
    logic [31:0]          r_line_base;
    logic [4:0]           r_issue_cnt;
    logic [4:0]           r_ret_cnt;
    logic                 r_rd_vld;
    logic [3:0]           r_rd_slot;
    logic [RD_LAT-1:0]    r_pipe_vld;
    logic [3:0]           r_pipe_slot [RD_LAT];

    logic [31:0] w_remaining;
    logic [4:0]  w_line_len;
    logic        w_issue;
    logic        w_ret;
    logic        w_wr_ok;
    logic        w_send_fire;
    logic        w_last_line;
    logic [8:0]  w_slot_lsb;
    logic [31:0] w_perf_field;

    assign w_remaining = NUM_PIX32 - r_line_base;
    assign w_line_len  = (w_remaining >= 32'd16) ? 5'd16 : w_remaining[4:0];
    assign w_issue     = (r_state == S_FILL) && (r_issue_cnt != w_line_len);
    assign w_ret       = r_pipe_vld[RD_LAT-1];
    assign w_slot_lsb  = {r_pipe_slot[RD_LAT-1], 5'd0};
    // Back-to-back writes are forbidden, so a write is only allowed when the previous cycle had none.
    assign w_wr_ok     = !c1_alm_full && !r_wr_valid;
    assign w_send_fire = (r_state == S_SEND) && w_wr_ok;
    assign w_last_line = (r_pix_idx >= NUM_PIX32);

`ifdef EDGE_WB_PERF_CNT_EN
    logic [31:0] r_perf_cnt;
    logic [31:0] r_perf_snap;
    logic [31:0] w_perf_next;

    assign w_perf_next  = (r_perf_cnt == 32'hFFFF_FFFF) ? r_perf_cnt : r_perf_cnt + 32'd1;
    assign w_perf_field = r_perf_snap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_cnt  <= '0;
            r_perf_snap <= '0;
        end else if (r_state == S_IDLE) begin
            if (cfg_start) r_perf_cnt <= '0;
        end else begin
            r_perf_cnt <= w_perf_next;
            if (w_send_fire && w_last_line) r_perf_snap <= w_perf_next;
        end
    end
`else
    assign w_perf_field = 32'h0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_acc_start     <= 1'b0;
            r_wr_valid      <= 1'b0;
            r_busy          <= 1'b0;
            r_acc_rd_addr   <= '0;
            r_dst_addr      <= '0;
            r_status_addr   <= '0;
            r_wr_addr       <= '0;
            r_wr_data       <= '0;
            r_lines_written <= '0;
            r_pix_idx       <= '0;
            r_line_base     <= '0;
            r_issue_cnt     <= '0;
            r_ret_cnt       <= '0;
            r_rd_vld        <= 1'b0;
            r_rd_slot       <= '0;
            r_pipe_vld      <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe_slot[i] <= '0;
        end else begin
            r_rd_vld   <= w_issue;
            r_wr_valid <= 1'b0;
            if (w_issue) begin
                r_acc_rd_addr <= r_pix_idx[RD_ADDR_W-1:0];
                r_rd_slot     <= r_issue_cnt[3:0];
                r_pix_idx     <= r_pix_idx + 32'd1;
                r_issue_cnt   <= r_issue_cnt + 5'd1;
            end
            r_pipe_vld[0]  <= r_rd_vld;
            r_pipe_slot[0] <= r_rd_slot;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                r_pipe_vld[i]  <= r_pipe_vld[i-1];
                r_pipe_slot[i] <= r_pipe_slot[i-1];
            end
            // The line is cleared right after it has been presented so unread slots of the next line stay zero.
            if (r_wr_valid) r_wr_data <= '0;
            if (w_ret) begin
                r_wr_data[w_slot_lsb +: 32] <= {8'h00, acc_rd_data};
                r_ret_cnt <= r_ret_cnt + 5'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_dst_addr      <= cfg_dst_addr;
                        r_status_addr   <= cfg_status_addr;
                        r_lines_written <= '0;
                        r_acc_start     <= 1'b1;
                        r_busy          <= 1'b1;
                        r_state         <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (acc_done) begin
                        r_acc_start <= 1'b0;
                        r_pix_idx   <= '0;
                        r_line_base <= '0;
                        r_issue_cnt <= '0;
                        r_ret_cnt   <= '0;
                        r_state     <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (r_issue_cnt == w_line_len && r_ret_cnt == w_line_len) r_state <= S_SEND;
                end
                S_SEND: begin
                    if (w_send_fire) begin
                        r_wr_valid      <= 1'b1;
                        r_wr_addr       <= r_dst_addr + ADDR_W'(r_lines_written);
                        r_lines_written <= r_lines_written + 32'd1;
                        r_line_base     <= r_pix_idx;
                        r_issue_cnt     <= '0;
                        r_ret_cnt       <= '0;
                        r_state         <= w_last_line ? S_STATUS : S_FILL;
                    end
                end
                S_STATUS: begin
                    if (w_wr_ok) begin
                        r_wr_valid <= 1'b1;
                        r_wr_addr  <= r_status_addr;
                        r_wr_data  <= {384'h0, w_perf_field, r_lines_written, 64'h1};
                        r_busy     <= 1'b0;
                        r_state    <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign acc_start     = r_acc_start;
    assign acc_rd_addr   = r_acc_rd_addr;
    assign wr_valid      = r_wr_valid;
    assign wr_addr       = r_wr_addr;
    assign wr_data       = r_wr_data;
    assign busy          = r_busy;
    assign lines_written = r_lines_written;
endmodule

// File: tb/tb_edge_result_wb_ctrl.sv
// tb/tb_edge_result_wb_ctrl.sv - randomized self-checking bench for edge_result_wb_ctrl (two parameter sets side by side)
module tb_edge_result_wb_ctrl;
    localparam int NI   = 2;
    localparam int NP0  = 32;
    localparam int NP1  = 20;
    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cfg_start = 1'b0;
    logic [41:0] cfg_dst = '0;
    logic [41:0] cfg_stat = '0;
    logic        alm = 1'b0;

    logic [1:0]   acc_start;
    logic [1:0]   acc_done = '0;
    logic [1:0]   wr_valid;
    logic [1:0]   busy;
    logic [18:0]  rd_addr [NI];
    logic [23:0]  rd_data [NI];
    logic [41:0]  wr_addr [NI];
    logic [511:0] wr_data [NI];
    logic [31:0]  lw      [NI];

    logic [23:0]  mem   [NI][64];
    logic [23:0]  rpipe [NI][3];
    int           done_dly = 3;
    bit           done_pulse = 1'b0;
    int           done_cnt [NI] = '{0, 0};
    logic [1:0]   done_kick = '0;

    logic [41:0]  exp_addr [NI][4];
    logic [511:0] exp_data [NI][4];
    int           exp_cnt  [NI] = '{0, 0};
    int           job_gen = 0;
    int           seen_gen = 0;
    int           ptr      [NI] = '{0, 0};
    int           busy_cnt [NI] = '{0, 0};
    logic [31:0]  perf_exp [NI] = '{0, 0};
    logic         alm_q = 1'b0;
    logic [1:0]   wv_q = '0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    function automatic int np_of(input int g);
        return (g == 0) ? NP0 : NP1;
    endfunction

    function automatic logic [41:0] rand42();
        return {10'($urandom), $urandom};
    endfunction

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_inst
        localparam int NP  = (g == 0) ? NP0 : NP1;
        localparam int LAT = (g == 0) ? LAT0 : LAT1;
        edge_result_wb_ctrl #(.NUM_PIXELS(NP), .RD_ADDR_W(19), .RD_LAT(LAT), .ADDR_W(42)) u_dut (
            .clk            (clk),
            .reset          (reset),
            .cfg_start      (cfg_start),
            .cfg_dst_addr   (cfg_dst),
            .cfg_status_addr(cfg_stat),
            .acc_start      (acc_start[g]),
            .acc_done       (acc_done[g]),
            .acc_rd_addr    (rd_addr[g]),
            .acc_rd_data    (rd_data[g]),
            .c1_alm_full    (alm),
            .wr_valid       (wr_valid[g]),
            .wr_addr        (wr_addr[g]),
            .wr_data        (wr_data[g]),
            .busy           (busy[g]),
            .lines_written  (lw[g])
        );
        assign rd_data[g] = rpipe[g][LAT-1];
    end

    // Result memory with a read latency line and an edge detector that finishes some cycles after start.
    always @(posedge clk) begin
        alm_q <= alm;
        for (int g = 0; g < NI; g++) begin
            rpipe[g][0] <= mem[g][rd_addr[g][5:0]];
            rpipe[g][1] <= rpipe[g][0];
            rpipe[g][2] <= rpipe[g][1];
            if (reset || acc_start[g] !== 1'b1) done_cnt[g] <= 0;
            else done_cnt[g] <= done_cnt[g] + 1;
            acc_done[g] <= done_kick[g] | ((acc_start[g] === 1'b1) &&
                           (done_pulse ? (done_cnt[g] == done_dly) : (done_cnt[g] >= done_dly)));
        end
    end

    always @(negedge clk) begin
        if (job_gen != seen_gen) begin
            seen_gen = job_gen;
            for (int g = 0; g < NI; g++) begin
                ptr[g] = 0;
                busy_cnt[g] = 0;
            end
        end
        for (int g = 0; g < NI; g++) begin
            if (wr_valid[g] === 1'b1) begin
                check($sformatf("b2b_wr%0d", g), 512'(wv_q[g]), 512'd0);
                check($sformatf("wr_in_almfull%0d", g), 512'(alm_q), 512'd0);
                if (ptr[g] >= exp_cnt[g]) begin
                    check($sformatf("unexpected_wr%0d", g), 512'(wr_valid[g]), 512'd0);
                end else begin
                    logic [511:0] d;
                    d = wr_data[g];
                    check($sformatf("wr_addr%0d_%0d", g, ptr[g]), 512'(wr_addr[g]), 512'(exp_addr[g][ptr[g]]));
                    if (ptr[g] == exp_cnt[g] - 1) begin
`ifdef EDGE_WB_PERF_CNT_EN
                        check($sformatf("perf%0d", g), 512'(d[127:96]), 512'(perf_exp[g]));
`else
                        check($sformatf("perf%0d", g), 512'(d[127:96]), 512'd0);
`endif
                        d[127:96] = '0;
                    end else if (ptr[g] == exp_cnt[g] - 2) begin
                        perf_exp[g] = busy_cnt[g];
                    end
                    check($sformatf("wr_data%0d_%0d", g, ptr[g]), d, exp_data[g][ptr[g]]);
                    ptr[g]++;
                end
            end
            if (busy[g] === 1'b1) busy_cnt[g]++;
            wv_q[g] = wr_valid[g];
        end
    end

    // mode: 0 plain, 1 random alm_full, 2 alm_full held 50 cycles, 3 stray cfg_start/acc_done, 4 reset mid-job
    task automatic run_job(input int mode, input int pat, input logic [41:0] dst, input logic [41:0] st);
        bit ok;
        job_gen++;
        done_dly   = (mode == 3) ? 6 : int'($urandom_range(1, 6));
        done_pulse = 1'($urandom);
        for (int g = 0; g < NI; g++) begin
            int nl;
            nl = (np_of(g) + 15) / 16;
            for (int n = 0; n < 64; n++)
                mem[g][n] = (pat == 0) ? 24'(n) : (pat == 1) ? (24'hABCDEF ^ 24'(n)) : 24'($urandom);
            for (int l = 0; l < nl; l++) begin
                logic [511:0] d;
                d = '0;
                for (int w = 0; w < 16; w++)
                    if (l * 16 + w < np_of(g)) d[32*w +: 32] = {8'h00, mem[g][l*16+w]};
                exp_addr[g][l] = dst + 42'(l);
                exp_data[g][l] = d;
            end
            exp_addr[g][nl] = st;
            exp_data[g][nl] = {384'h0, 32'h0, 32'(nl), 64'h1};
            exp_cnt[g] = nl + 1;
        end
        @(negedge clk);
        cfg_dst = dst;
        cfg_stat = st;
        cfg_start = 1'b1;
        @(negedge clk);
        cfg_start = 1'b0;
        cfg_dst = rand42();
        cfg_stat = rand42();
        ok = 1'b0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            cfg_start = 1'b0;
            if (busy == 2'b00) begin
                ok = 1'b1;
                break;
            end
            if (mode == 1) alm = ($urandom_range(0, 2) == 0);
            if (mode == 2 && cyc == 30) alm = 1'b1;
            if (mode == 2 && cyc == 80) alm = 1'b0;
            if (mode == 3 && (cyc == 2 || cyc == 24 || cyc == 26) && busy == 2'b11) begin
                cfg_start = 1'b1;
                cfg_dst = rand42();
                cfg_stat = rand42();
            end
            if (mode == 4 && cyc == 30) begin
                reset = 1'b1;
                @(negedge clk);
                for (int g = 0; g < NI; g++) begin
                    exp_cnt[g] = 0;
                    check($sformatf("rst_busy%0d", g), 512'(busy[g]), 512'd0);
                    check($sformatf("rst_wr_valid%0d", g), 512'(wr_valid[g]), 512'd0);
                    check($sformatf("rst_acc_start%0d", g), 512'(acc_start[g]), 512'd0);
                    check($sformatf("rst_lines%0d", g), 512'(lw[g]), 512'd0);
                end
                reset = 1'b0;
                repeat (40) @(negedge clk);
                check("rst_stays_idle", 512'(busy), 512'd0);
                alm = 1'b0;
                return;
            end
        end
        alm = 1'b0;
        cfg_start = 1'b0;
        check("job_timeout", 512'(ok), 512'd1);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("lines_written%0d", g), 512'(lw[g]), 512'((np_of(g) + 15) / 16));
            check($sformatf("write_count%0d", g), 512'(ptr[g]), 512'(exp_cnt[g]));
        end
        if (mode == 3) begin
            done_kick = 2'b11;
            @(negedge clk);
            done_kick = 2'b00;
            repeat (10) @(negedge clk);
            check("done_in_idle_busy", 512'(busy), 512'd0);
            check("done_in_idle_start", 512'(acc_start), 512'd0);
        end
    endtask

    initial begin
        for (int g = 0; g < NI; g++)
            for (int n = 0; n < 64; n++) mem[g][n] = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("reset_acc_start%0d", g), 512'(acc_start[g]), 512'd0);
            check($sformatf("reset_rd_addr%0d", g), 512'(rd_addr[g]), 512'd0);
            check($sformatf("reset_wr_valid%0d", g), 512'(wr_valid[g]), 512'd0);
            check($sformatf("reset_wr_addr%0d", g), 512'(wr_addr[g]), 512'd0);
            check($sformatf("reset_wr_data%0d", g), wr_data[g], 512'd0);
            check($sformatf("reset_busy%0d", g), 512'(busy[g]), 512'd0);
            check($sformatf("reset_lines%0d", g), 512'(lw[g]), 512'd0);
        end
        run_job(0, 0, 42'h100, 42'h200);
        run_job(1, 2, rand42(), rand42());
        run_job(2, 2, rand42(), rand42());
        run_job(3, 2, rand42(), rand42());
        run_job(4, 2, rand42(), rand42());
        run_job(0, 2, rand42(), rand42());
        run_job(0, 1, 42'h3FF_FFFF_FFFF, rand42());
        for (int j = 0; j < 6; j++)
            run_job(int'($urandom_range(0, 3)), 2, rand42(), rand42());
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
